parity_stream_tx: RTL

//  Serial transmitter for the team's 1-bit parity-class receiver (even/odd 1s x even/odd 0s).

---
 rtl/parity_stream_pkg.sv | 21 ++
 rtl/parity_class_track.sv | 21 ++
 rtl/parity_stream_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/parity_stream_pkg.sv
// Shared definitions for the parity-class stream transmitter and its matching receiver.
package parity_stream_pkg;

  localparam logic [1:0] CLS_EE = 2'b00;
  localparam logic [1:0] CLS_OE = 2'b01;
  localparam logic [1:0] CLS_EO = 2'b10;
  localparam logic [1:0] CLS_OO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TRL1 = 2'd2,
    TRL0 = 2'd3
  } tx_state_e;

  // A 1 flips the 1s-parity bit, a 0 flips the 0s-parity bit.
  function automatic logic [1:0] cls_step(input logic [1:0] cur, input logic b);
    return cur ^ (b ? CLS_OE : CLS_EO);
  endfunction

endpackage

// File: rtl/parity_class_track.sv
// Running parity class of a serial bit stream; cleared at frame start.
module parity_class_track
  import parity_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_valid,
  input  logic       bit_val,
  output logic [1:0] par_state
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      par_state <= CLS_EE;
    end else if (bit_valid) begin
      par_state <= cls_step(par_state, bit_val);
    end
  end

endmodule

// File: rtl/parity_stream_tx.sv
// Serial LSB-first word transmitter that appends a 0-2 bit trailer so each frame
// lands in the requested even/odd 1s x even/odd 0s class.
module parity_stream_tx
  import parity_stream_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data,
  input  logic [1:0]   cls,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_last,
  output logic [1:0]   par_state
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  tx_state_e      state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           need1_q, need0_q;
  logic           accept, need1_a, need0_a;
  logic           sout_d, valid_d, last_d, ready_d;

  assign accept = (state_q == IDLE) && start;

  // Trailer needs are known from the whole payload, so resolve them at accept
  // rather than from the lagging registered par_state.
  assign need1_a = (^data) ^ cls[0];
  assign need0_a = (^(~data)) ^ cls[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      need1_q    <= 1'b0;
      need0_q    <= 1'b0;
      ready      <= 1'b1;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ready      <= ready_d;
      sout       <= sout_d;
      sout_valid <= valid_d;
      sout_last  <= last_d;
      if (accept) begin
        need1_q <= need1_a;
        need0_q <= need0_a;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = DATA;
      DATA: if (cnt_q == LAST_IDX) state_d = need1_q ? TRL1 : (need0_q ? TRL0 : IDLE);
      TRL1: state_d = need0_q ? TRL0 : IDLE;
      TRL0: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered, so the
  // state register always names what is currently on sout.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sout_d  = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    ready_d = 1'b0;
    if (accept) begin
      shift_d = data >> 1;
      cnt_d   = '0;
    end else if (state_q == DATA && cnt_q != LAST_IDX) begin
      shift_d = shift_q >> 1;
      cnt_d   = cnt_q + CW'(1);
    end
    unique case (state_d)
      IDLE: ready_d = 1'b1;
      DATA: begin
        valid_d = 1'b1;
        sout_d  = (state_q == IDLE) ? data[0] : shift_q[0];
        last_d  = (cnt_d == LAST_IDX) && !need1_q && !need0_q;
      end
      TRL1: begin
        valid_d = 1'b1;
        sout_d  = 1'b1;
        last_d  = !need0_q;
      end
      TRL0: begin
        valid_d = 1'b1;
        last_d  = 1'b1;
      end
      default: ready_d = 1'b1;
    endcase
  end

  parity_class_track u_track (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .bit_valid (sout_valid),
    .bit_val   (sout),
    .par_state (par_state)
  );

endmodule
